// File: rtl/sar_logic.sv
// Successive-approximation controller: sequences the sample phase and N
// binary-search bit trials, drives the comparator clock/power-down and the
// CDAC trial code, and assembles the N-bit result from comparator decisions.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; comparator powered down if PWDN_IDLE
// SAMPLE  | track/hold switch closed for SAMP_CYC cycles
// SETTLE  | trial code on the CDAC, settling for SETTLE_CYC cycles
// EVAL    | comparator clock high, decision developing
// RESOLVE | comparator clock high, decision captured at the closing edge
// DONE    | result valid, one-cycle done pulse
module sar_logic #(
    parameter int N          = 8,
    parameter int SAMP_CYC   = 2,
    parameter int SETTLE_CYC = 1,
    parameter int PWDN_IDLE  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dout,
    input  logic         doutb,
    output logic         clk_cmp,
    output logic         pwdn_cmp,
    output logic         sample,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         err
);

    localparam int SW = (SAMP_CYC > 1) ? $clog2(SAMP_CYC) : 1;
    localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int IW = $clog2(N);

    localparam logic [SW-1:0] SAMP_LD   = SW'(SAMP_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [IW-1:0] IDX_MSB   = IW'(N - 1);
    localparam logic [N-1:0]  ONE       = N'(1);
    localparam logic [N-1:0]  CODE_MSB  = ONE << (N - 1);
    localparam logic          PWDN_RST  = (PWDN_IDLE != 0);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        EVAL,
        RESOLVE,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] samp_cnt, samp_nxt;
    logic [TW-1:0] settle_cnt, settle_nxt;
    logic [IW-1:0] bit_idx, idx_nxt, idx_dec;
    logic [N-1:0]  w, w_nxt;
    logic [N-1:0]  dac_nxt, res_nxt;
    logic          err_nxt;
    logic          sample_nxt, clk_cmp_nxt, busy_nxt, done_nxt, pwdn_nxt;

    assign idx_dec = bit_idx - IW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath and output decode; outputs are decoded from the
    // next state so every port comes straight off a flop.
    always_comb begin
        state_nxt  = state;
        samp_nxt   = samp_cnt;
        settle_nxt = settle_cnt;
        idx_nxt    = bit_idx;
        w_nxt      = w;
        dac_nxt    = dac_code;
        res_nxt    = result;
        err_nxt    = err;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SAMPLE;
                    samp_nxt  = SAMP_LD;
                    err_nxt   = 1'b0;
                    dac_nxt   = CODE_MSB;
                end
            end
            SAMPLE: begin
                idx_nxt = IDX_MSB;
                w_nxt   = '0;
                if (samp_cnt == '0) begin
                    state_nxt  = SETTLE;
                    settle_nxt = SETTLE_LD;
                    dac_nxt    = CODE_MSB;
                end else begin
                    samp_nxt = samp_cnt - SW'(1);
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = EVAL;
                end else begin
                    settle_nxt = settle_cnt - TW'(1);
                end
            end
            EVAL: begin
                state_nxt = RESOLVE;
            end
            RESOLVE: begin
                // An unresolved comparator (outputs equal) counts as a 0 decision.
                w_nxt[bit_idx] = dout & ~doutb;
                if (dout == doutb) begin
                    err_nxt = 1'b1;
                end
                if (bit_idx == '0) begin
                    state_nxt = DONE;
                    res_nxt   = w_nxt;
                end else begin
                    state_nxt  = SETTLE;
                    idx_nxt    = idx_dec;
                    settle_nxt = SETTLE_LD;
                    dac_nxt    = w_nxt | (ONE << idx_dec);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        sample_nxt  = (state_nxt == SAMPLE);
        clk_cmp_nxt = (state_nxt == EVAL) || (state_nxt == RESOLVE);
        busy_nxt    = (state_nxt != IDLE);
        done_nxt    = (state_nxt == DONE);
        pwdn_nxt    = (state_nxt == IDLE) && PWDN_RST;
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt   <= '0;
            settle_cnt <= '0;
            bit_idx    <= '0;
            w          <= '0;
            dac_code   <= '0;
            result     <= '0;
            err        <= 1'b0;
            sample     <= 1'b0;
            clk_cmp    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pwdn_cmp   <= PWDN_RST;
        end else begin
            samp_cnt   <= samp_nxt;
            settle_cnt <= settle_nxt;
            bit_idx    <= idx_nxt;
            w          <= w_nxt;
            dac_code   <= dac_nxt;
            result     <= res_nxt;
            err        <= err_nxt;
            sample     <= sample_nxt;
            clk_cmp    <= clk_cmp_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pwdn_cmp   <= pwdn_nxt;
        end
    end

endmodule

// File: tb/tb_sar_logic.sv
// Directed bench for sar_logic with an ideal comparator model
// (dout = vin >= dac_code) and a hook to force an unresolved decision.
module tb_sar_logic;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dout;
    logic         doutb;
    logic         clk_cmp;
    logic         pwdn_cmp;
    logic         sample;
    logic [N-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         err;

    logic [N-1:0] vin;
    logic         frc;

    int n_vec = 0;
    int n_err = 0;

    // Observations captured by run_conv
    logic [N-1:0] tr [0:7];
    int           done_cyc, ndone, npulse, nbadw, nsamp;
    logic [N-1:0] res_d;
    logic         err_d, err_c1;
    logic [10:0]  rs_snap;

    sar_logic #(.N(8), .SAMP_CYC(2), .SETTLE_CYC(1), .PWDN_IDLE(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dout     (dout),
        .doutb    (doutb),
        .clk_cmp  (clk_cmp),
        .pwdn_cmp (pwdn_cmp),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err)
    );

    always #5 clk = ~clk;

    assign dout  = frc ? 1'b0 : (vin >= dac_code);
    assign doutb = frc ? 1'b0 : ~(vin >= dac_code);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one conversion (start high across edge 0), then observe cycles
    // 1..ncyc. frc_c forces an unresolved decision in that cycle, rst_c
    // asserts reset in that cycle, p1/p2 pulse start in those cycles.
    task automatic run_conv(input logic [N-1:0] v, input int frc_c, input int rst_c,
                            input int p1, input int p2, input int ncyc);
        int hi;
        hi = 0;
        vin = v;
        done_cyc = 0; ndone = 0; npulse = 0; nbadw = 0; nsamp = 0;
        res_d = '0; err_d = 1'b0; err_c1 = 1'b0; rs_snap = '0;
        for (int k = 0; k < 8; k++) tr[k] = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c == 1) err_c1 = err;
            if (rst_c > 0 && c == rst_c + 1) rs_snap = {busy, clk_cmp, done, result};
            if (clk_cmp) begin
                if (hi == 0) begin
                    if (npulse < 8) tr[npulse] = dac_code;
                    npulse++;
                end
                hi++;
            end else begin
                if (hi != 0 && hi != 2) nbadw++;
                hi = 0;
            end
            if (sample) nsamp++;
            if (done) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    res_d = result;
                    err_d = err;
                end
            end
            frc   = (c == frc_c);
            rst   = (c == rst_c);
            start = (c == p1) || (c == p2);
            tick();
        end
        frc = 1'b0; rst = 1'b0; start = 1'b0;
    endtask

    logic [N-1:0] seq_a5 [0:7];
    int           dc [0:2];
    int           nd;

    initial begin
        seq_a5[0] = 8'h80; seq_a5[1] = 8'hC0; seq_a5[2] = 8'hA0; seq_a5[3] = 8'hB0;
        seq_a5[4] = 8'hA8; seq_a5[5] = 8'hA4; seq_a5[6] = 8'hA6; seq_a5[7] = 8'hA5;

        rst = 1'b1; start = 1'b0; frc = 1'b0; vin = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_clk_cmp", clk_cmp, 0);
        check("rst_sample", sample, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_dac", dac_code, 0);
        check("rst_result", result, 0);
        check("rst_pwdn", pwdn_cmp, 1);

        // Vector 1: A5
        vin = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("a5_busy_c1", busy, 1);
        check("a5_pwdn_c1", pwdn_cmp, 0);
        check("a5_sample_c1", sample, 1);
        check("a5_dac_c1", dac_code, 8'h80);
        repeat (30) tick();
        run_conv(8'hA5, 0, 0, 0, 0, 40);
        check("a5_done_cyc", done_cyc, 27);
        check("a5_ndone", ndone, 1);
        check("a5_result", res_d, 8'hA5);
        check("a5_err", err_d, 0);
        check("a5_nsamp", nsamp, 2);
        for (int k = 0; k < 8; k++) check($sformatf("a5_trial%0d", k), tr[k], seq_a5[k]);
        check("a5_idle_busy", busy, 0);
        check("a5_idle_pwdn", pwdn_cmp, 1);

        // Vector 2: full scale and zero
        run_conv(8'hFF, 0, 0, 0, 0, 40);
        check("ff_result", res_d, 8'hFF);
        check("ff_npulse", npulse, 8);
        check("ff_badwidth", nbadw, 0);
        run_conv(8'h00, 0, 0, 0, 0, 40);
        check("00_result", res_d, 8'h00);
        check("00_final_dac", dac_code, 8'h01);
        check("00_npulse", npulse, 8);
        check("00_badwidth", nbadw, 0);
        check("00_done_cyc", done_cyc, 27);

        // Vector 3: unresolved decision on bit 3 (its RESOLVE is cycle 17)
        run_conv(8'hFF, 17, 0, 0, 0, 40);
        check("frc_result", res_d, 8'hF7);
        check("frc_err", err_d, 1);
        check("frc_err_sticky", err, 1);
        run_conv(8'hA5, 0, 0, 0, 0, 40);
        check("frc_err_clr", err_c1, 0);
        check("frc_next_result", res_d, 8'hA5);

        // Vector 4: reset in cycle 10 of a conversion
        run_conv(8'h3C, 0, 10, 0, 0, 40);
        check("rstm_busy", rs_snap[10], 0);
        check("rstm_clk_cmp", rs_snap[9], 0);
        check("rstm_done", rs_snap[8], 0);
        check("rstm_result", rs_snap[7:0], 0);
        check("rstm_ndone", ndone, 0);
        run_conv(8'h5A, 0, 0, 0, 0, 40);
        check("rstm_after_result", res_d, 8'h5A);
        check("rstm_after_cyc", done_cyc, 27);

        // Vector 5: start while busy is ignored
        run_conv(8'h3C, 0, 0, 5, 20, 40);
        check("busy_ndone", ndone, 1);
        check("busy_done_cyc", done_cyc, 27);
        check("busy_result", res_d, 8'h3C);
        check("busy_idle", busy, 0);

        // start held high: back-to-back conversions
        vin = 8'h69;
        nd = 0;
        for (int k = 0; k < 3; k++) dc[k] = 0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 90; c++) begin
            if (done) begin
                if (nd < 3) dc[nd] = c;
                nd++;
                check($sformatf("hold_result%0d", nd), result, 8'h69);
            end
            tick();
        end
        start = 1'b0;
        check("hold_ndone", nd, 3);
        check("hold_done0", dc[0], 27);
        check("hold_done1", dc[1], 55);
        check("hold_done2", dc[2], 83);
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
